// File: rtl/pat_tx.sv
// Serial pattern transmitter: parallel word + bit count in, MSB-first bit stream out.
// Optional inter-word idle gap enabled by defining PAT_TX_GAP_EN.
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   SHIFT | emitting bits, counter holds bits remaining including current
//   GAP   | forced idle after each word (PAT_TX_GAP_EN only)
module pat_tx #(
   parameter int WIDTH    = 8,
   parameter int GAP_BITS = 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [WIDTH-1:0]             in_data,
   input  logic [$clog2(WIDTH+1)-1:0]   in_len,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         out,
   output logic                         out_valid,
   output logic                         done
);

   localparam int LW = $clog2(WIDTH+1);

   if (WIDTH < 2) begin : g_width_chk
      $error("pat_tx: WIDTH must be >= 2");
   end
   if (GAP_BITS < 1) begin : g_gap_chk
      $error("pat_tx: GAP_BITS must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PAT_TX_GAP_EN
      , GAP = 2'd2
`endif
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [LW-1:0]    cnt;
   logic [LW-1:0]    eff_len;
   logic [LW-1:0]    shamt;
   logic [WIDTH-1:0] load_word;
   logic             last;
   logic             accept;
   logic             load;

`ifdef PAT_TX_GAP_EN
   localparam int GW = $clog2(GAP_BITS+1);
   logic [GW-1:0]    gap_cnt;
`endif

   always_comb begin
      eff_len   = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
      shamt     = LW'(WIDTH) - eff_len;
      load_word = in_data << shamt;
   end

   assign last = (state == SHIFT) && (cnt == LW'(1));

`ifdef PAT_TX_GAP_EN
   assign in_ready = (state == IDLE);
`else
   assign in_ready = (state == IDLE) || last;
`endif

   assign accept    = in_valid && in_ready;
   // A zero-length word completes the handshake but is dropped.
   assign load      = accept && (eff_len != '0);
   assign out_valid = (state == SHIFT);
   assign out       = out_valid && sreg[WIDTH-1];
   assign done      = last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
`ifdef PAT_TX_GAP_EN
         gap_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  sreg  <= load_word;
                  cnt   <= eff_len;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sreg <= sreg << 1;
               cnt  <= cnt - LW'(1);
               if (last) begin
`ifdef PAT_TX_GAP_EN
                  state   <= GAP;
                  gap_cnt <= GW'(GAP_BITS);
`else
                  if (load) begin
                     sreg <= load_word;
                     cnt  <= eff_len;
                  end else begin
                     state <= IDLE;
                  end
`endif
               end
            end
`ifdef PAT_TX_GAP_EN
            GAP: begin
               gap_cnt <= gap_cnt - GW'(1);
               if (gap_cnt == GW'(1)) state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pat_tx.sv
// Scoreboard bench for pat_tx: stimulus pushes cycle-tagged expected bits,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_pat_tx;

   localparam int WIDTH    = 8;
   localparam int GAP_BITS = 2;
   localparam int LW       = $clog2(WIDTH+1);

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic [LW-1:0]    in_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready, out, out_valid, done;

   typedef struct {
      int   cyc;
      logic b;
      logic last;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   busy_until = -1000;
   int   checks = 0;
   int   errors = 0;

   pat_tx #(.WIDTH(WIDTH), .GAP_BITS(GAP_BITS)) dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_len(in_len),
      .in_valid(in_valid), .in_ready(in_ready), .out(out),
      .out_valid(out_valid), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_ready(input int c);
`ifdef PAT_TX_GAP_EN
      return c > busy_until + GAP_BITS;
`else
      return c >= busy_until;
`endif
   endfunction

   // Monitor: expected bit for this cycle sits at the queue head, if any.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("stale_entry", 32'(q[0].cyc), 32'(cyc));
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_bit", 32'(out), 32'(e.b));
            chk("done", 32'(done), 32'(e.last));
         end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_idle", 32'(out), 32'd0);
            chk("done_idle", 32'(done), 32'd0);
         end
      end
   end

   // One cycle of stimulus; returns whether the model accepted a non-dropped or dropped word.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [LW-1:0] l,
                        output bit acc);
      bit rdy;
      int len_eff;
      @(negedge clk);
      rdy = model_ready(cyc);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      in_valid = v;
      in_data  = d;
      in_len   = l;
      acc = v && rdy && rstn;
      if (acc) begin
         len_eff = (int'(l) > WIDTH) ? WIDTH : int'(l);
         for (int i = 0; i < len_eff; i++) begin
            exp_t e;
            e.cyc  = cyc + 1 + i;
            e.b    = d[len_eff-1-i];
            e.last = (i == len_eff - 1);
            q.push_back(e);
         end
         if (len_eff > 0) busy_until = cyc + len_eff;
      end
   endtask

   task automatic send_word(input logic [WIDTH-1:0] d, input logic [LW-1:0] l);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         drive(1'b1, d, l, acc);
         n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, acc);
   endtask

   initial begin
      bit acc;
      idle(2);
      rstn = 1'b1;
      idle(2);

      send_word(8'h0B, 4'd4);
      idle(6);
      send_word(8'h0B, 4'd4);
      send_word(8'h0B, 4'd4);
      idle(12);
      send_word(8'hFF, 4'd0);
      idle(3);
      send_word(8'hA5, 4'd12);
      idle(12);

      // Reset in the middle of a word
      send_word(8'hF0, 4'd8);
      idle(2);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      q.delete();
      busy_until = -1000;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 8'h55, 4'd4, acc);
      idle(1);
      rstn = 1'b1;
      send_word(8'h0B, 4'd4);
      idle(8);

      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
               LW'($urandom_range(0, (1 << LW) - 1)), acc);
      end

      for (int i = 0; i < 64 && q.size() > 0; i++) idle(1);
      chk("drain_empty", 32'(q.size()), 32'd0);
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pat_tx.md
# pat_tx

Serial pattern transmitter: accepts a parallel word plus a bit count over a valid/ready handshake, then shifts the selected bits out MSB-first, one bit per clock, on a single-bit serial line.
- Serves as the driving end of the serial bit-stream interface consumed by the sequence detectors, e.g. a 1011 detector.
- Lets test environments and on-chip stimulus logic emit arbitrary bit sequences, back-to-back or gapped.

## Interface
Parameters:
- WIDTH, 8, maximum bits per word (>= 2).
- GAP_BITS, 2, idle cycles inserted between words; only used when PAT_TX_GAP_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  word to transmit; bits [len-1:0] are used.
- in_len  input  $clog2(WIDTH+1)  number of bits to send.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit; 0 whenever out_valid is 0.
- out_valid  output  1  out carries a pattern bit this cycle.
- done  output  1  high during the cycle the last bit of a word is on out.

## Operation
- States: IDLE, SHIFT, GAP (GAP exists only with PAT_TX_GAP_EN).
- Accept occurs on a rising edge with in_valid && in_ready.
- Length handling at accept:
  - Effective length L = min(in_len, WIDTH).
  - L = 0: the word is consumed and dropped. State stays IDLE; no out_valid, no done.
- Load at accept (L >= 1):
  - Shift register <= in_data << (WIDTH-L).
  - Bit counter <= L.
  - State -> SHIFT.
- SHIFT state:
  - out = shift register MSB; out_valid = 1.
  - Each cycle: shift left by 1, counter decrements.
  - Bits appear in order in_data[L-1] down to in_data[0].
  - done = 1 when counter == 1.
- Leaving SHIFT at counter == 1:
  - Without gap: if a new word is accepted on this edge, load it and stay in SHIFT (no bubble). Otherwise go to IDLE.
  - With gap: go to GAP.
- GAP state: out = 0, out_valid = 0, in_ready = 0 for GAP_BITS cycles (gap counter), then IDLE.
- in_ready:
  - 1 in IDLE.
  - 1 in SHIFT with counter == 1 only when the gap is disabled.
  - 0 otherwise.
- in_data and in_len are sampled only at accept. Later changes have no effect on a word in flight.
- Outputs are decoded from registered state only; no combinational path from in_* to out, out_valid or done.

## Timing
- Reset values: state IDLE, counters 0, shift register 0.
  - out = 0, out_valid = 0, done = 0.
  - in_ready = 1 (IDLE decode), including while rstn is low. Handshakes during reset are ignored.
- Latency: word accepted at edge k → first bit on out in cycle k+1. The last bit is in cycle k+L, with done in that cycle.
- Throughput without gap: continuous; one bit per clock across words when in_valid is held.
- Throughput with gap: L + GAP_BITS cycles per word, plus 1 cycle in IDLE for the next accept.
- Reset mid-word (rstn falling): out, out_valid and done go to 0 immediately, without waiting for clk. The partial word is discarded.
- in_valid dropped while in_ready is 0: no effect, no word lost (nothing was accepted).

## Configuration
- PAT_TX_GAP_EN defined:
  - GAP state present; GAP_BITS idle cycles follow every word.
  - The last-bit accept path is removed, so in_ready is 1 only in IDLE.
- PAT_TX_GAP_EN undefined:
  - No GAP state; GAP_BITS is ignored.
  - Back-to-back words are emitted contiguously.

## Test plan
- Single word, WIDTH=8, in_data=8'h0B, in_len=4, accept at edge 0 → out = 1,0,1,1 in cycles 1–4. out_valid is high for exactly those 4 cycles; done is high in cycle 4 only.
- Back-to-back, macro off, two words 8'h0B/len 4 with in_valid held → out_valid high 8 consecutive cycles, out = 1,0,1,1,1,0,1,1. in_ready high in cycles 0 and 4; done in cycles 4 and 8.
- in_len=0, in_data=8'hFF → handshake completes, out_valid stays 0, done stays 0, in_ready stays 1.
- in_len=12 (clamped to 8), in_data=8'hA5 → out = 1,0,1,0,0,1,0,1 over 8 cycles, done on the 8th.
- Reset mid-word: 8'hF0/len 8, rstn low after 2 bits → out/out_valid drop to 0 immediately. After release, 8'h0B/len 4 produces 1,0,1,1 cleanly.
- Macro on, GAP_BITS=2, two words 8'h0B/len 4 with in_valid held → bits 1,0,1,1 then 2 cycles out_valid=0. Then 1 IDLE cycle, then 1,0,1,1.
